next_pc_predictor: RTL and testbench
====================================

# next_pc_predictor

Fetch-stage next-PC generator that sits directly upstream of the PC register and drives its `next_PC` and stall inputs. It holds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, predicts the next fetch address from the current PC, and learns from branch/jump outcomes resolved in EX. On a misprediction it redirects fetch to the correct address and raises `flush` for the IF/ID and ID/EX registers.

## Interface
Parameters:
- `ENTRIES`, 16, BTB entries; power of two, ≥2.
- `IDX_W`, $clog2(ENTRIES), index width; index = PC[IDX_W+1:2], tag = PC[31:IDX_W+2].

Ports:
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `PC`  in  32  current fetch PC (output of the PC register).
- `stall_in`  in  1  hazard-unit stall request (load-use).
- `ex_valid`  in  1  EX holds a valid control-transfer instruction this cycle.
- `ex_jump`  in  1  EX instruction is JAL/JALR (0 = conditional branch).
- `ex_pc`  in  32  PC of the EX instruction.
- `ex_taken`  in  1  resolved direction (jumps: 1).
- `ex_target`  in  32  resolved target address.
- `ex_pred_taken`  in  1  prediction made at fetch, carried down the pipe.
- `ex_pred_target`  in  32  predicted target, carried down the pipe.
- `next_PC`  out  32  address to load into the PC register.
- `pred_taken`  out  1  prediction for current `PC`; goes into IF/ID.
- `pred_target`  out  32  predicted target for current `PC`; goes into IF/ID.
- `flush`  out  1  kill IF/ID and ID/EX contents.
- `stall_out`  out  1  stall to the PC register.

## Operation
- Lookup (combinational on `PC`): hit = valid[idx] & tag[idx]==PC tag. `pred_taken` = hit & ctr[idx]≥2. `pred_target` = target[idx] when hit, else PC+4.
- Mispredict (combinational, only when `ex_valid`): `ex_taken != ex_pred_taken`, or both taken and `ex_target != ex_pred_target`.
- `next_PC` priority: mispredict → (`ex_taken` ? `ex_target` : `ex_pc`+4); else `pred_taken` → `pred_target`; else PC+4. All adds 32-bit, wrap modulo 2^32.
- `flush` = mispredict. `stall_out` = `stall_in` & ~mispredict (redirect always overrides stall).
- Update at posedge when `ex_valid` & ~`rst`, indexed by `ex_pc`:
  - Hit: counter saturating ±1 (inc on taken, dec on not-taken; 3 and 0 saturate); if taken, target ← `ex_target`.
  - Miss and taken: allocate/replace entry: valid=1, tag, target=`ex_target`, ctr = 3 if `ex_jump` else 2.
  - Miss and not-taken: no change.
- Updates occur regardless of `stall_in`.
- Counter states: SNT(0), WNT(1), WT(2), ST(3).

## Timing
- Lookup: zero latency; prediction for `PC` valid in the same cycle.
- Update: written at the rising edge ending the EX cycle; visible to lookup from the next cycle. Same-cycle lookup and update to one index: lookup sees old contents (no bypass).
- Redirect: `next_PC` correction and `flush` asserted in the same cycle as the mispredicting EX instruction; corrected PC fetched the following cycle.
- Reset: while `rst` high all valid bits and counters clear at the edge; outputs are combinational, so with empty BTB after reset `pred_taken`=0, `pred_target`=PC+4, `next_PC`=PC+4, `flush`=0 (given `ex_valid`=0). Reset mid-operation discards all BTB contents; any in-flight EX update that edge is dropped.
- `ex_valid`=0: `flush`=0, no state change, ex_* ignored.

## Structure
- Package `bp_pkg`: counter enum `ctr_t` (SNT/WNT/WT/ST), `btb_entry_t` struct {valid, tag, target, ctr}, default `ENTRIES`.
- One sub-module: `btb_array` (storage, reset clear, combinational read port, synchronous write port). Predictor logic, mispredict detect and next-PC mux stay in the top.

## Test plan
- Post-reset: rst 1 cycle, PC=0x0 → pred_taken=0, next_PC=0x4, flush=0.
- Learn branch: ex_valid, ex_pc=0x10, ex_taken=1, ex_target=0x40, ex_pred_taken=0 → flush=1, next_PC=0x40; next cycle PC=0x10 → pred_taken=1, pred_target=0x40 (ctr=WT).
- Hysteresis: same entry resolved not-taken once → ctr=WNT, flush=1, next_PC=0x14; next lookup of 0x10 → pred_taken=0; one further taken resolve → ctr=WT, predicts taken again.
- Wrong target: JALR at 0x20 predicted 0x80, resolves 0x90 → flush=1, next_PC=0x90, entry target becomes 0x90, ctr=ST.
- Alias: with ENTRIES=16, PC 0x10 entry present, resolve taken branch at 0x50 → replaces entry; lookup 0x10 → miss, next_PC=0x14.
- Stall vs redirect: stall_in=1 with mispredict → stall_out=0, flush=1; stall_in=1 without mispredict → stall_out=1, BTB update still performed.

Source files
------------

// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and helpers for the next-PC predictor
package bp_pkg;

    localparam int ENTRIES = 16;
    // Tag is kept at its widest possible size (IDX_W >= 1); upper bits are zero for larger tables.
    localparam int TAG_W   = 30;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_t;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [31:0]       target;
        ctr_t              ctr;
    } btb_entry_t;

    localparam int ENTRY_W = $bits(btb_entry_t);

    function automatic ctr_t ctr_update(input ctr_t c, input logic taken);
        ctr_t n;
        n = c;
        case (c)
            SNT:     n = taken ? WNT : SNT;
            WNT:     n = taken ? WT  : SNT;
            WT:      n = taken ? ST  : WNT;
            ST:      n = taken ? ST  : WT;
            default: n = c;
        endcase
        return n;
    endfunction

    function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc, input int idx_w);
        return pc[31:2] >> idx_w;
    endfunction

endpackage

// File: rtl/btb_array.sv
// rtl/btb_array.sv - BTB storage with two combinational read ports and one write port
module btb_array
    import bp_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [IDX_W-1:0]   rd_a_idx_i,
    output logic [ENTRY_W-1:0] rd_a_o,
    input  logic [IDX_W-1:0]   rd_b_idx_i,
    output logic [ENTRY_W-1:0] rd_b_o,
    input  logic               we_i,
    input  logic [IDX_W-1:0]   wr_idx_i,
    input  logic [ENTRY_W-1:0] wr_data_i
);

    btb_entry_t mem_q [ENTRIES];

    // Only valid and counter need clearing; stale tag/target are masked by valid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem_q[i].valid <= 1'b0;
                mem_q[i].ctr   <= SNT;
            end
        end else if (we_i) begin
            mem_q[wr_idx_i] <= btb_entry_t'(wr_data_i);
        end
    end

    assign rd_a_o = mem_q[rd_a_idx_i];
    assign rd_b_o = mem_q[rd_b_idx_i];

endmodule

// File: rtl/next_pc_predictor.sv
// rtl/next_pc_predictor.sv - BTB-based next-PC generator with EX-stage learning and redirect
module next_pc_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = bp_pkg::ENTRIES,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    input  logic        stall_in,
    input  logic        ex_valid,
    input  logic        ex_jump,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic [31:0] next_PC,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    output logic        flush,
    output logic        stall_out
);

    logic [IDX_W-1:0]   f_idx, e_idx;
    logic [TAG_W-1:0]   f_tag, e_tag;
    logic [ENTRY_W-1:0] f_vec, e_vec, wr_vec;
    btb_entry_t         f_ent, e_ent, wr_ent;
    logic               f_hit, e_hit, wr_en, mispredict;
    logic [31:0]        pc_plus4, ex_pc_plus4;

    assign f_idx = PC[IDX_W+1:2];
    assign e_idx = ex_pc[IDX_W+1:2];
    assign f_tag = pc_tag(PC, IDX_W);
    assign e_tag = pc_tag(ex_pc, IDX_W);

    btb_array #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W)
    ) u_btb (
        .clk_i      (clk),
        .rst_i      (rst),
        .rd_a_idx_i (f_idx),
        .rd_a_o     (f_vec),
        .rd_b_idx_i (e_idx),
        .rd_b_o     (e_vec),
        .we_i       (wr_en),
        .wr_idx_i   (e_idx),
        .wr_data_i  (wr_vec)
    );

    assign f_ent = btb_entry_t'(f_vec);
    assign e_ent = btb_entry_t'(e_vec);
    assign f_hit = f_ent.valid && (f_ent.tag == f_tag);
    assign e_hit = e_ent.valid && (e_ent.tag == e_tag);

    assign pc_plus4    = PC + 32'd4;
    assign ex_pc_plus4 = ex_pc + 32'd4;

    assign pred_taken  = f_hit && (f_ent.ctr >= WT);
    assign pred_target = f_hit ? f_ent.target : pc_plus4;

    assign mispredict = ex_valid &&
                        ((ex_taken != ex_pred_taken) ||
                         (ex_taken && ex_pred_taken && (ex_target != ex_pred_target)));

    always_comb begin
        next_PC = pc_plus4;
        if (mispredict) begin
            next_PC = ex_taken ? ex_target : ex_pc_plus4;
        end else if (pred_taken) begin
            next_PC = pred_target;
        end
    end

    assign flush     = mispredict;
    assign stall_out = stall_in && !mispredict;

    // Training is independent of stall; a hit refines, a taken miss (re)allocates.
    always_comb begin
        wr_en  = 1'b0;
        wr_ent = e_ent;
        if (ex_valid) begin
            if (e_hit) begin
                wr_en      = 1'b1;
                wr_ent.ctr = ctr_update(e_ent.ctr, ex_taken);
                if (ex_taken) begin
                    wr_ent.target = ex_target;
                end
            end else if (ex_taken) begin
                wr_en         = 1'b1;
                wr_ent.valid  = 1'b1;
                wr_ent.tag    = e_tag;
                wr_ent.target = ex_target;
                wr_ent.ctr    = ex_jump ? ST : WT;
            end
        end
    end

    assign wr_vec = wr_ent;

endmodule

// File: tb/tb_next_pc_predictor.sv
// tb/tb_next_pc_predictor.sv - directed self-checking bench for next_pc_predictor
module tb_next_pc_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] PC;
    logic        stall_in;
    logic        ex_valid;
    logic        ex_jump;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic [31:0] next_PC;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        flush;
    logic        stall_out;

    int errors = 0;
    int checks = 0;

    next_pc_predictor #(.ENTRIES(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .PC             (PC),
        .stall_in       (stall_in),
        .ex_valid       (ex_valid),
        .ex_jump        (ex_jump),
        .ex_pc          (ex_pc),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .next_PC        (next_PC),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .flush          (flush),
        .stall_out      (stall_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_set(input logic v, input logic j, input logic [31:0] pc, input logic t,
                          input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
        ex_valid       = v;
        ex_jump        = j;
        ex_pc          = pc;
        ex_taken       = t;
        ex_target      = tgt;
        ex_pred_taken  = pt;
        ex_pred_target = ptgt;
    endtask

    initial begin
        rst = 1'b1;
        PC = 32'h0;
        stall_in = 1'b0;
        ex_set(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("reset_pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("reset_pred_target", pred_target, 32'h4);
        chk("reset_next_pc", next_PC, 32'h4);
        chk("reset_flush", {31'd0, flush}, 32'd0);
        chk("reset_stall_out", {31'd0, stall_out}, 32'd0);

        // Learn taken branch at 0x10; same-cycle lookup of 0x10 still sees the empty entry
        PC = 32'h10;
        ex_set(1'b1, 1'b0, 32'h10, 1'b1, 32'h40, 1'b0, 32'h14);
        #1;
        chk("learn_flush", {31'd0, flush}, 32'd1);
        chk("learn_next_pc", next_PC, 32'h40);
        chk("learn_no_bypass", {31'd0, pred_taken}, 32'd0);
        tick();
        ex_set(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        chk("learned_pred_taken", {31'd0, pred_taken}, 32'd1);
        chk("learned_pred_target", pred_target, 32'h40);
        chk("learned_next_pc", next_PC, 32'h40);
        chk("learned_flush", {31'd0, flush}, 32'd0);

        // Hysteresis: one not-taken drops WT to WNT
        PC = 32'h200;
        ex_set(1'b1, 1'b0, 32'h10, 1'b0, 32'h40, 1'b1, 32'h40);
        #1;
        chk("hyst_nt_flush", {31'd0, flush}, 32'd1);
        chk("hyst_nt_next_pc", next_PC, 32'h14);
        tick();
        ex_set(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        PC = 32'h10;
        #1;
        chk("hyst_wnt_pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("hyst_wnt_pred_target", pred_target, 32'h40);
        chk("hyst_wnt_next_pc", next_PC, 32'h14);
        ex_set(1'b1, 1'b0, 32'h10, 1'b1, 32'h40, 1'b0, 32'h14);
        #1;
        chk("hyst_t_next_pc", next_PC, 32'h40);
        tick();
        ex_set(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        chk("hyst_wt_pred_taken", {31'd0, pred_taken}, 32'd1);

        // Correct prediction under stall: no flush, stall passes through, update still trains to ST
        PC = 32'h300;
        stall_in = 1'b1;
        ex_set(1'b1, 1'b0, 32'h10, 1'b1, 32'h40, 1'b1, 32'h40);
        #1;
        chk("stall_ok_stall_out", {31'd0, stall_out}, 32'd1);
        chk("stall_ok_flush", {31'd0, flush}, 32'd0);
        chk("stall_ok_next_pc", next_PC, 32'h304);
        tick();
        // Mispredict under stall: redirect wins
        ex_set(1'b1, 1'b0, 32'h10, 1'b0, 32'h40, 1'b1, 32'h40);
        #1;
        chk("stall_mis_stall_out", {31'd0, stall_out}, 32'd0);
        chk("stall_mis_flush", {31'd0, flush}, 32'd1);
        chk("stall_mis_next_pc", next_PC, 32'h14);
        tick();
        stall_in = 1'b0;
        ex_set(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        PC = 32'h10;
        #1;
        chk("stall_update_kept", {31'd0, pred_taken}, 32'd1);

        // JALR at 0x20 allocates as ST, then resolves to a different target
        ex_set(1'b1, 1'b1, 32'h20, 1'b1, 32'h80, 1'b0, 32'h24);
        tick();
        ex_set(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        PC = 32'h20;
        #1;
        chk("jalr_alloc_target", pred_target, 32'h80);
        chk("jalr_alloc_taken", {31'd0, pred_taken}, 32'd1);
        PC = 32'h100;
        ex_set(1'b1, 1'b1, 32'h20, 1'b1, 32'h90, 1'b1, 32'h80);
        #1;
        chk("wrong_tgt_flush", {31'd0, flush}, 32'd1);
        chk("wrong_tgt_next_pc", next_PC, 32'h90);
        tick();
        ex_set(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        PC = 32'h20;
        #1;
        chk("wrong_tgt_new_target", pred_target, 32'h90);
        chk("wrong_tgt_next_pc2", next_PC, 32'h90);
        // One not-taken from ST must still predict taken
        PC = 32'h100;
        ex_set(1'b1, 1'b1, 32'h20, 1'b0, 32'h90, 1'b1, 32'h90);
        #1;
        chk("st_nt_next_pc", next_PC, 32'h24);
        tick();
        ex_set(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        PC = 32'h20;
        #1;
        chk("st_after_nt_taken", {31'd0, pred_taken}, 32'd1);

        // Alias: 0x50 shares index 4 with 0x10 and replaces it
        ex_set(1'b1, 1'b0, 32'h50, 1'b1, 32'h60, 1'b0, 32'h54);
        tick();
        ex_set(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        PC = 32'h10;
        #1;
        chk("alias_old_taken", {31'd0, pred_taken}, 32'd0);
        chk("alias_old_target", pred_target, 32'h14);
        chk("alias_old_next_pc", next_PC, 32'h14);
        PC = 32'h50;
        #1;
        chk("alias_new_next_pc", next_PC, 32'h60);

        // Reset mid-operation drops contents and the in-flight update
        rst = 1'b1;
        ex_set(1'b1, 1'b0, 32'h30, 1'b1, 32'h70, 1'b0, 32'h34);
        tick();
        rst = 1'b0;
        ex_set(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        PC = 32'h30;
        #1;
        chk("rst_drop_update", next_PC, 32'h34);
        PC = 32'h20;
        #1;
        chk("rst_clear_taken", {31'd0, pred_taken}, 32'd0);
        chk("rst_clear_target", pred_target, 32'h24);

        // Address wrap
        PC = 32'hFFFF_FFFC;
        #1;
        chk("wrap_pc_next", next_PC, 32'h0);
        ex_set(1'b1, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h8, 1'b1, 32'h8);
        #1;
        chk("wrap_ex_next", next_PC, 32'h0);
        chk("wrap_ex_flush", {31'd0, flush}, 32'd1);
        tick();
        ex_set(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
